instr_fetch: RTL

Instruction fetch stage directly downstream of the PC register. It takes the current PC, issues in-order read requests to instruction memory over a valid/ready handshake, and buffers the returned words with their PCs in a small queue. The decode stage consumes fetched instructions from that queue through a second valid/ready handshake. The block also drives the next-PC value back into the PC register, covering sequential +4 advance, hold on stall, and branch/jump redirect with flush of stale in-flight fetches.

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/instr_fetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: data widths, NOP encoding, queue entry layout.
package instr_fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Word-align a fetch target by clearing the two low address bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO with clear and occupancy count; head word is
// read combinationally from storage. DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Clear takes priority over a same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order imem reads from pc_q, queues returned
// words with their PCs for decode, and computes next PC with redirect/flush.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 1;
  // Stale responses can accumulate across back-to-back redirects.
  localparam int unsigned DW = CW + 4;

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [DW-1:0]   discard;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    q_push_entry;
  fetch_entry_t    q_head;
  logic            fire;
  logic            pop;
  logic            rsp_owed;
  logic            rsp_accept;

  // Credit check uses registered counts only, so if_ready never reaches the request.
  assign imem_req_valid = !rst && !redirect && ((SW'(inflight) + SW'(q_count)) < SW'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign if_valid = (q_count != '0);
  assign pop      = if_valid && if_ready;
  assign if_instr = q_head.instr;
  assign if_pc    = q_head.pc;

  assign rsp_owed     = (discard != '0) || (inflight != '0);
  assign rsp_accept   = imem_rsp_valid && !rst && !redirect && (discard == '0) && (inflight != '0);
  assign q_push_entry = '{pc: tag_head, instr: imem_rsp_data};

  always_comb begin
    pc_next = pc_q;
    if (rst)           pc_next = '0;
    else if (redirect) pc_next = align_pc(redirect_pc);
    else if (fire)     pc_next = pc_q + XLEN'(4);
  end

  // On redirect every outstanding request becomes stale; one may retire this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      discard  <= '0;
    end else if (redirect) begin
      inflight <= '0;
      discard  <= discard + DW'(inflight) - DW'(imem_rsp_valid && rsp_owed);
    end else begin
      inflight <= inflight + CW'(fire) - CW'(rsp_accept);
      if (imem_rsp_valid && (discard != '0)) discard <= discard - DW'(1);
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (rsp_accept),
    .push_data (q_push_entry),
    .pop       (pop),
    .head_data (q_head),
    .count     (q_count)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (fire),
    .push_data (pc_q),
    .pop       (rsp_accept),
    .head_data (tag_head),
    .count     (tag_count)
  );

  a_rsp_owed: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> rsp_owed);
  a_tag_sync: assert property (@(posedge clk) disable iff (rst) tag_count == inflight);
endmodule
